// File: rtl/sent_rx_fast_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module : sent_rx_fast_frame_decoder
// Brief  : SENT fast-channel receiver - pulse timing, sync lock, nibble decode
// Rev    : 1.0
// ============================================================================
module sent_rx_fast_frame_decoder #(
  parameter int TICK_CLKS  = 4,
  parameter int SYNC_TICKS = 56,
  parameter int SYNC_TOL   = 1,
  parameter int MAX_TICKS  = 1023
) (
  input  logic        clk_rx,
  input  logic        reset_rx,
  input  logic        sent_rx,
  output logic [27:0] data_fast_check_crc,
  output logic [3:0]  status_nibble,
  output logic [2:0]  enable_crc_check,
  output logic        frame_error,
  output logic        sync_locked
);

  localparam int                 c_sub_w     = $clog2(TICK_CLKS);
  localparam logic [c_sub_w-1:0] c_sub_load  = c_sub_w'(TICK_CLKS / 2);
  localparam logic [c_sub_w-1:0] c_sub_last  = c_sub_w'(TICK_CLKS - 1);
  localparam logic [c_sub_w-1:0] c_sub_one   = c_sub_w'(1);
  localparam logic [9:0]         c_max_ticks = 10'(MAX_TICKS);
  localparam logic [9:0]         c_sync_min  = 10'(SYNC_TICKS - SYNC_TOL);
  localparam logic [9:0]         c_sync_max  = 10'(SYNC_TICKS + SYNC_TOL);
  localparam logic [9:0]         c_nib_min   = 10'd12;
  localparam logic [9:0]         c_nib_max   = 10'd27;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_SYNC = 3'd1,
    ST_STATUS    = 3'd2,
    ST_DATA      = 3'd3,
    ST_CRC       = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sync1, r_sync2, r_sync_prev;
  logic               w_fall;
  logic [c_sub_w-1:0] r_sub;
  logic [9:0]         r_ticks;
  logic               w_stall;
  logic               w_nib_valid;
  logic [3:0]         w_nib;
  logic               w_sync_ok;
  logic [2:0]         r_idx;
  logic [3:0]         r_status_sh;
  logic [23:0]        r_data_sh;
  logic               w_err;
  logic               w_done;
  logic               w_lock_set;
  logic               w_lock_clr;

  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync_prev <= 1'b0;
    end else begin
      r_sync1     <= sent_rx;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_fall = r_sync_prev & ~r_sync2;

  // Sub-counter preloaded with half a tick so widths round to the nearest tick
  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      r_sub   <= '0;
      r_ticks <= '0;
    end else if (w_fall) begin
      r_sub   <= c_sub_load;
      r_ticks <= '0;
    end else if (r_sub == c_sub_last) begin
      r_sub <= '0;
      if (r_ticks != c_max_ticks) r_ticks <= r_ticks + 10'd1;
    end else begin
      r_sub <= r_sub + c_sub_one;
    end
  end

  assign w_nib_valid = (r_ticks >= c_nib_min) && (r_ticks <= c_nib_max);
  assign w_nib       = r_ticks[3:0] - 4'd12;
  assign w_sync_ok   = (r_ticks >= c_sync_min) && (r_ticks <= c_sync_max);
  assign w_stall     = (r_state != ST_IDLE) && (r_ticks == c_max_ticks);

  always_ff @(posedge clk_rx) begin
    if (reset_rx) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_done      = 1'b0;
    w_lock_set  = 1'b0;
    w_lock_clr  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_fall) w_state_nxt = ST_WAIT_SYNC;
      end
      ST_WAIT_SYNC: begin
        if (w_fall && w_sync_ok) begin
          w_state_nxt = ST_STATUS;
          w_lock_set  = 1'b1;
        end
      end
      ST_STATUS, ST_DATA: begin
        if (w_fall) begin
          if (!w_nib_valid) begin
            w_err       = 1'b1;
            w_lock_clr  = 1'b1;
            w_state_nxt = ST_WAIT_SYNC;
          end else if (r_state == ST_STATUS) begin
            w_state_nxt = ST_DATA;
          end else if (r_idx == 3'd5) begin
            w_state_nxt = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (w_fall) begin
          w_state_nxt = ST_WAIT_SYNC;
          if (w_nib_valid) begin
            w_done = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_lock_clr = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // A coincident edge takes priority over the stall
    if (!w_fall && w_stall) begin
      w_state_nxt = ST_IDLE;
      w_err       = sync_locked;
      w_lock_clr  = 1'b1;
    end
  end

  always_ff @(posedge clk_rx) begin
    if (reset_rx) begin
      r_idx               <= '0;
      r_status_sh         <= '0;
      r_data_sh           <= '0;
      data_fast_check_crc <= '0;
      status_nibble       <= '0;
      enable_crc_check    <= '0;
      frame_error         <= 1'b0;
      sync_locked         <= 1'b0;
    end else begin
      frame_error      <= w_err;
      enable_crc_check <= w_done ? 3'b001 : 3'b000;
      if (w_lock_set)      sync_locked <= 1'b1;
      else if (w_lock_clr) sync_locked <= 1'b0;
      if (w_fall && w_nib_valid) begin
        case (r_state)
          ST_STATUS: begin
            r_status_sh <= w_nib;
            r_idx       <= '0;
          end
          ST_DATA: begin
            r_data_sh <= {r_data_sh[19:0], w_nib};
            r_idx     <= r_idx + 3'd1;
          end
          ST_CRC: begin
            data_fast_check_crc <= {r_data_sh, w_nib};
            status_nibble       <= r_status_sh;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sent_rx_fast_frame_decoder.sv
`default_nettype none
// Directed bench for sent_rx_fast_frame_decoder with hand-computed frames.
module tb_sent_rx_fast_frame_decoder;

  localparam int TICK_CLKS = 4;

  logic        clk_rx   = 1'b0;
  logic        reset_rx = 1'b1;
  logic        sent_rx  = 1'b1;
  logic [27:0] data_fast_check_crc;
  logic [3:0]  status_nibble;
  logic [2:0]  enable_crc_check;
  logic        frame_error;
  logic        sync_locked;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc = 0;
  int last_fall_cyc = 0;
  int strobe_cnt = 0;
  int err_cnt = 0;
  int run = 0;
  int max_run = 0;
  int bad_en = 0;
  int last_lat = 0;

  sent_rx_fast_frame_decoder #(
    .TICK_CLKS (TICK_CLKS),
    .SYNC_TICKS(56),
    .SYNC_TOL  (1),
    .MAX_TICKS (1023)
  ) dut (
    .clk_rx             (clk_rx),
    .reset_rx           (reset_rx),
    .sent_rx            (sent_rx),
    .data_fast_check_crc(data_fast_check_crc),
    .status_nibble      (status_nibble),
    .enable_crc_check   (enable_crc_check),
    .frame_error        (frame_error),
    .sync_locked        (sync_locked)
  );

  always #5 clk_rx = ~clk_rx;

  always @(posedge clk_rx) cyc <= cyc + 1;

  always @(negedge clk_rx) begin
    if (enable_crc_check == 3'b001) begin
      strobe_cnt <= strobe_cnt + 1;
      run        <= run + 1;
      last_lat   <= cyc - last_fall_cyc;
      if (run + 1 > max_run) max_run <= run + 1;
    end else begin
      run <= 0;
      if (enable_crc_check != 3'b000) bad_en <= bad_en + 1;
    end
    if (frame_error) err_cnt <= err_cnt + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // One SENT pulse: falling edge, 4 ticks low, remainder high
  task automatic pulse(input int ticks);
    sent_rx       = 1'b0;
    last_fall_cyc = cyc;
    repeat (4 * TICK_CLKS) @(negedge clk_rx);
    sent_rx = 1'b1;
    repeat ((ticks - 4) * TICK_CLKS) @(negedge clk_rx);
  endtask

  task automatic send_body(input logic [3:0] st, input logic [23:0] d, input logic [3:0] crc);
    pulse(12 + int'(st));
    for (int i = 0; i < 6; i++) pulse(12 + int'(d[23 - 4*i -: 4]));
    pulse(12 + int'(crc));
  endtask

  task automatic send_frame(input int sync, input logic [3:0] st, input logic [23:0] d,
                            input logic [3:0] crc);
    pulse(sync);
    send_body(st, d, crc);
  endtask

  task automatic settle();
    repeat (8) @(negedge clk_rx);
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_data"}, 32'(data_fast_check_crc), 32'h0);
    check_val({tag, "_status"}, 32'(status_nibble), 32'h0);
    check_val({tag, "_enable"}, 32'(enable_crc_check), 32'h0);
    check_val({tag, "_error"}, 32'(frame_error), 32'h0);
    check_val({tag, "_locked"}, 32'(sync_locked), 32'h0);
  endtask

  initial begin
    repeat (4) @(negedge clk_rx);
    check_zero_outputs("reset");
    reset_rx = 1'b0;
    repeat (4) @(negedge clk_rx);

    // Nominal frame
    send_frame(56, 4'h0, 24'h123456, 4'h7);
    pulse(20);
    settle();
    check_val("A_strobes", 32'(strobe_cnt), 32'd1);
    check_val("A_data", 32'(data_fast_check_crc), 32'h1234567);
    check_val("A_status", 32'(status_nibble), 32'h0);
    check_val("A_errors", 32'(err_cnt), 32'd0);
    check_val("A_locked", 32'(sync_locked), 32'd1);
    check_val("A_latency_3to4", 32'((last_lat >= 3) && (last_lat <= 4)), 32'd1);

    // 55-tick sync, within tolerance, after a pause
    send_frame(55, 4'h0, 24'h123456, 4'h7);
    pulse(20);
    settle();
    check_val("B_strobes", 32'(strobe_cnt), 32'd2);
    check_val("B_data", 32'(data_fast_check_crc), 32'h1234567);
    check_val("B_errors", 32'(err_cnt), 32'd0);

    // 58-tick sync from a clean state must not lock
    reset_rx = 1'b1;
    @(negedge clk_rx);
    reset_rx = 1'b0;
    send_frame(58, 4'h0, 24'h123456, 4'h7);
    pulse(20);
    settle();
    check_val("S58_strobes", 32'(strobe_cnt), 32'd2);
    check_val("S58_errors", 32'(err_cnt), 32'd0);
    check_val("S58_locked", 32'(sync_locked), 32'd0);
    check_val("S58_data", 32'(data_fast_check_crc), 32'h0);

    // Good frame, then one broken by a 30-tick pulse at data index 2
    send_frame(56, 4'hA, 24'h987654, 4'h3);
    pulse(20);
    settle();
    check_val("C_strobes", 32'(strobe_cnt), 32'd3);
    check_val("C_data", 32'(data_fast_check_crc), 32'h9876543);
    check_val("C_status", 32'(status_nibble), 32'hA);
    pulse(56);
    pulse(13);
    pulse(13);
    pulse(14);
    pulse(30);
    pulse(20);
    settle();
    check_val("ERR_errors", 32'(err_cnt), 32'd1);
    check_val("ERR_locked", 32'(sync_locked), 32'd0);
    check_val("ERR_strobes", 32'(strobe_cnt), 32'd3);
    check_val("ERR_data_held", 32'(data_fast_check_crc), 32'h9876543);
    check_val("ERR_status_held", 32'(status_nibble), 32'hA);

    // Back-to-back frames
    send_frame(56, 4'h5, 24'hFEDCBA, 4'h0);
    pulse(56);
    check_val("D_strobes", 32'(strobe_cnt), 32'd4);
    check_val("D_data", 32'(data_fast_check_crc), 32'hFEDCBA0);
    check_val("D_status", 32'(status_nibble), 32'h5);
    send_body(4'h3, 24'h000001, 4'h2);
    pulse(20);
    settle();
    check_val("E_strobes", 32'(strobe_cnt), 32'd5);
    check_val("E_data", 32'(data_fast_check_crc), 32'h0000012);
    check_val("E_status", 32'(status_nibble), 32'h3);
    check_val("E_errors", 32'(err_cnt), 32'd1);

    // Line stall after sync
    pulse(56);
    sent_rx       = 1'b0;
    last_fall_cyc = cyc;
    repeat (4 * TICK_CLKS) @(negedge clk_rx);
    sent_rx = 1'b1;
    repeat (1100 * TICK_CLKS) @(negedge clk_rx);
    check_val("STALL_errors", 32'(err_cnt), 32'd2);
    check_val("STALL_locked", 32'(sync_locked), 32'd0);
    check_val("STALL_data_held", 32'(data_fast_check_crc), 32'h0000012);
    send_frame(56, 4'h2, 24'h654321, 4'h0);
    pulse(20);
    settle();
    check_val("F_strobes", 32'(strobe_cnt), 32'd6);
    check_val("F_data", 32'(data_fast_check_crc), 32'h6543210);
    check_val("F_status", 32'(status_nibble), 32'h2);
    check_val("F_errors", 32'(err_cnt), 32'd2);

    // Reset while receiving data index 3
    pulse(56);
    pulse(13);
    pulse(13);
    pulse(14);
    pulse(15);
    sent_rx       = 1'b0;
    last_fall_cyc = cyc;
    repeat (8) @(negedge clk_rx);
    reset_rx = 1'b1;
    @(negedge clk_rx);
    check_zero_outputs("MIDRST");
    reset_rx = 1'b0;
    repeat (7) @(negedge clk_rx);
    sent_rx = 1'b1;
    repeat (16 * TICK_CLKS - 16) @(negedge clk_rx);
    pulse(17);
    pulse(18);
    pulse(19);
    pulse(20);
    settle();
    check_val("G_strobes", 32'(strobe_cnt), 32'd6);
    check_val("G_data", 32'(data_fast_check_crc), 32'h0);
    check_val("G_errors", 32'(err_cnt), 32'd2);

    send_frame(56, 4'h4, 24'hABCDEF, 4'h9);
    pulse(20);
    settle();
    check_val("H_strobes", 32'(strobe_cnt), 32'd7);
    check_val("H_data", 32'(data_fast_check_crc), 32'hABCDEF9);
    check_val("H_status", 32'(status_nibble), 32'h4);
    check_val("H_locked", 32'(sync_locked), 32'd1);
    check_val("H_errors", 32'(err_cnt), 32'd2);
    check_val("strobe_width", 32'(max_run), 32'd1);
    check_val("enable_codes", 32'(bad_en), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
